audio_echo_stage: RTL and testbench

- Parametrised stereo echo/delay effect; successor to the fixed square-wave tone injector.
- Sits between the Audio_Controller read side (left/right_channel_audio_in) and its write side (left/right_channel_audio_out), and owns the read_audio_in/write_audio_out handshake.
- Mixes each dry sample with a delayed, attenuated copy from an on-chip circular buffer.
- Delay length, attenuation and enable are runtime inputs, driven from switches in the top level.

---
 rtl/audio_fx_pkg.sv | 30 +++
 rtl/audio_echo_stage_if.sv | 30 +++
 rtl/audio_echo_ram.sv | 22 ++
 rtl/audio_echo_stage.sv | 140 ++++++++++++++
 tb/tb_audio_echo_stage.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_fx_pkg.sv
// Shared types and helpers for the audio effect blocks: FSM state encoding,
// default sample widths and a width-generic saturating adder.
package audio_fx_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int STORE_W_DEF = 16;
  localparam int SAT_MAX_W   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MIX   = 2'd2,
    WRITE = 2'd3
  } echo_state_t;

  // Clamp a (w+1)-bit signed sum, sign-extended into SAT_MAX_W+1 bits, to the w-bit range.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(input logic signed [SAT_MAX_W:0] sum,
                                                          input int w);
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    one = (SAT_MAX_W+1)'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (sum > hi) return hi[SAT_MAX_W-1:0];
    if (sum < lo) return lo[SAT_MAX_W-1:0];
    return sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/audio_echo_stage_if.sv
// Audio_Controller stream handshake. The effect stage owns the pop/push strobes (master);
// the controller side supplies samples and FIFO status (slave).
interface audio_echo_stage_if
  import audio_fx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              audio_in_available;
  logic              audio_out_allowed;
  logic [DATA_W-1:0] left_channel_audio_in;
  logic [DATA_W-1:0] right_channel_audio_in;
  logic              read_audio_in;
  logic              write_audio_out;
  logic [DATA_W-1:0] left_channel_audio_out;
  logic [DATA_W-1:0] right_channel_audio_out;

  modport master (
    input  audio_in_available, audio_out_allowed,
    input  left_channel_audio_in, right_channel_audio_in,
    output read_audio_in, write_audio_out,
    output left_channel_audio_out, right_channel_audio_out
  );

  modport slave (
    output audio_in_available, audio_out_allowed,
    output left_channel_audio_in, right_channel_audio_in,
    input  read_audio_in, write_audio_out,
    input  left_channel_audio_out, right_channel_audio_out
  );
endinterface

// File: rtl/audio_echo_ram.sv
// Simple dual-port delay-line RAM: one write port, one synchronous read port, no reset,
// so it maps onto block RAM.
module audio_echo_ram
  import audio_fx_pkg::*;
#(
  parameter int WIDTH  = 2 * STORE_W_DEF,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/audio_echo_stage.sv
// Stereo echo stage: dry + attenuated delayed copy, one frame per four cycles.
// Define ECHO_FEEDBACK_EN to store the mixed output (repeating echo); default stores the dry input.
module audio_echo_stage
  import audio_fx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int STORE_W = STORE_W_DEF,
  parameter int ADDR_W  = 14,
  parameter int SHIFT_W = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  delay_len,
  input  logic [SHIFT_W-1:0] decay_shift,
  audio_echo_stage_if.master aud
);
  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(DEPTH - 1);

  function automatic logic signed [DATA_W-1:0] wet_of(input logic [STORE_W-1:0]  st,
                                                      input logic [SHIFT_W-1:0] sh);
    logic signed [DATA_W-1:0] full;
    full = signed'(DATA_W'(st)) <<< (DATA_W - STORE_W);
    return full >>> sh;
  endfunction

  function automatic logic signed [DATA_W-1:0] mix_ch(input logic signed [DATA_W-1:0] dry,
                                                      input logic signed [DATA_W-1:0] wet);
    logic signed [DATA_W:0]      sum;
    logic signed [SAT_MAX_W-1:0] sat;
    sum = (DATA_W+1)'(dry) + (DATA_W+1)'(wet);
    sat = sat_add((SAT_MAX_W+1)'(sum), DATA_W);
    return sat[DATA_W-1:0];
  endfunction

  echo_state_t                 state, state_nxt;
  logic                        start, read_nxt, write_nxt;
  logic [ADDR_W-1:0]           wr_ptr, fill_cnt, rd_addr;
  logic [2*STORE_W-1:0]        rd_word, store_word;
  logic [STORE_W-1:0]          st_l, st_r;
  logic                        wet_on;
  logic signed [DATA_W-1:0]    wet_l, wet_r, mix_l, mix_r;
  logic signed [DATA_W-1:0]    dry_l_p0, dry_r_p0, mix_l_p1, mix_r_p1;
  logic                        en_p0;
  logic [SHIFT_W-1:0]          shift_p0;
  logic [ADDR_W-1:0]           deff_p0;

  assign start = (state == IDLE) && aud.audio_in_available && aud.audio_out_allowed;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = MIX;
      MIX:     state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read_nxt  = 1'b0;
    write_nxt = 1'b0;
    if (start)          read_nxt  = 1'b1;
    if (state == WRITE) write_nxt = 1'b1;
  end

  // ---- p0: frame capture (delay_len already fits DEPTH-1, so it is d_eff as-is)
  always_ff @(posedge CLOCK_50) begin
    if (start) begin
      dry_l_p0 <= signed'(aud.left_channel_audio_in);
      dry_r_p0 <= signed'(aud.right_channel_audio_in);
      en_p0    <= enable;
      shift_p0 <= decay_shift;
      deff_p0  <= delay_len;
    end
  end

  // ---- fetch: address presented in FETCH, RAM word valid in MIX
  assign rd_addr        = wr_ptr - deff_p0;
  assign {st_l, st_r}   = rd_word;
  assign wet_on         = en_p0 && (deff_p0 != '0) && (fill_cnt >= deff_p0);
  assign wet_l          = wet_on ? wet_of(st_l, shift_p0) : '0;
  assign wet_r          = wet_on ? wet_of(st_r, shift_p0) : '0;
  assign mix_l          = mix_ch(dry_l_p0, wet_l);
  assign mix_r          = mix_ch(dry_r_p0, wet_r);

  // ---- p1: mixed frame, held for the WRITE cycle
  always_ff @(posedge CLOCK_50) begin
    if (state == MIX) begin
      mix_l_p1 <= mix_l;
      mix_r_p1 <= mix_r;
    end
  end

`ifdef ECHO_FEEDBACK_EN
  assign store_word = {mix_l_p1[DATA_W-1 -: STORE_W], mix_r_p1[DATA_W-1 -: STORE_W]};
`else
  assign store_word = {dry_l_p0[DATA_W-1 -: STORE_W], dry_r_p0[DATA_W-1 -: STORE_W]};
`endif

  audio_echo_ram #(
    .WIDTH  (2 * STORE_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (CLOCK_50),
    .wr_en   (write_nxt),
    .wr_addr (wr_ptr),
    .wr_data (store_word),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  // ---- output: registered strobes and samples, delay-line bookkeeping
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      aud.read_audio_in           <= 1'b0;
      aud.write_audio_out         <= 1'b0;
      aud.left_channel_audio_out  <= '0;
      aud.right_channel_audio_out <= '0;
      wr_ptr                      <= '0;
      fill_cnt                    <= '0;
    end else begin
      aud.read_audio_in   <= read_nxt;
      aud.write_audio_out <= write_nxt;
      if (write_nxt) begin
        aud.left_channel_audio_out  <= mix_l_p1;
        aud.right_channel_audio_out <= mix_r_p1;
        wr_ptr                      <= wr_ptr + 1'b1;
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_audio_echo_stage.sv
// Self-checking bench for audio_echo_stage: directed and randomized frames against a
// frame-history reference model (small delay RAM so wrap-around is reachable).
module tb_audio_echo_stage;
  import audio_fx_pkg::*;

  localparam int DW    = 32;
  localparam int SW    = 16;
  localparam int AW    = 6;
  localparam int SHW   = 3;
  localparam int DEPTH = 2**AW;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [AW-1:0]  delay_len;
  logic [SHW-1:0] decay_shift;
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [DW-1:0]  last_el, last_er;

  audio_echo_stage_if #(.DATA_W(DW)) aud();

  audio_echo_stage #(
    .DATA_W(DW), .STORE_W(SW), .ADDR_W(AW), .SHIFT_W(SHW)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .delay_len   (delay_len),
    .decay_shift (decay_shift),
    .aud         (aud)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } frame_t;

  frame_t hist[$];

  // Reference: wet = stored sample in the top bits, arithmetically shifted; saturating sum.
  function automatic logic [DW-1:0] ref_mix(input logic [DW-1:0] dry, input logic [SW-1:0] st,
                                            input bit wet_on, input int sh);
    longint wet, s, maxv, minv;
    logic [DW-1:0] top;
    maxv = (longint'(1) <<< (DW - 1)) - 1;
    minv = -(longint'(1) <<< (DW - 1));
    top  = {st, {(DW-SW){1'b0}}};
    wet  = 0;
    if (wet_on) wet = longint'($signed(top)) >>> sh;
    s = longint'($signed(dry)) + wet;
    if (s > maxv) s = maxv;
    if (s < minv) s = minv;
    return DW'(s);
  endfunction

  task automatic model_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit en,
                             input int d, input int sh,
                             output logic [DW-1:0] el, output logic [DW-1:0] er);
    int     n;
    bit     wet_on;
    frame_t st, sv;
    n      = hist.size();
    wet_on = en && (d != 0) && (n >= d);
    st     = '0;
    if (wet_on) st = hist[n-d];
    el = ref_mix(l, st.l, wet_on, sh);
    er = ref_mix(r, st.r, wet_on, sh);
`ifdef ECHO_FEEDBACK_EN
    sv.l = el[DW-1 -: SW];
    sv.r = er[DW-1 -: SW];
`else
    sv.l = l[DW-1 -: SW];
    sv.r = r[DW-1 -: SW];
`endif
    hist.push_back(sv);
    last_el = el;
    last_er = er;
  endtask

  // Drive one frame; inputs are scrambled once the pop strobe is seen (must not matter).
  task automatic run_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit en,
                           input int d, input int sh,
                           output logic [DW-1:0] ol, output logic [DW-1:0] orr,
                           output int lat, output int nreads);
    int t;
    lat    = -1;
    nreads = 0;
    ol     = '0;
    orr    = '0;
    @(negedge clk);
    aud.left_channel_audio_in  = l;
    aud.right_channel_audio_in = r;
    enable                     = en;
    delay_len                  = AW'(d);
    decay_shift                = SHW'(sh);
    aud.audio_in_available     = 1'b1;
    aud.audio_out_allowed      = 1'b1;
    t = 0;
    while (aud.read_audio_in !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (aud.read_audio_in === 1'b1) begin
      nreads = 1;
      aud.audio_in_available     = 1'b0;
      aud.left_channel_audio_in  = $urandom();
      aud.right_channel_audio_in = $urandom();
      enable                     = 1'($urandom_range(0, 1));
      delay_len                  = AW'($urandom());
      decay_shift                = SHW'($urandom());
      for (int c = 1; c <= 8 && lat < 0; c++) begin
        @(negedge clk);
        if (aud.read_audio_in === 1'b1) nreads++;
        if (aud.write_audio_out === 1'b1) begin
          lat = c;
          ol  = aud.left_channel_audio_out;
          orr = aud.right_channel_audio_out;
        end
      end
    end
    aud.audio_in_available = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset_n = 1'b0;
    aud.audio_in_available = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hist.delete();
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    aud.audio_in_available = 1'b1;
    aud.audio_out_allowed  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (aud.read_audio_in !== 1'b0) begin n_bad++; $display("FAIL reset_read: got %0b want 0", aud.read_audio_in); end
    n_cmp++; if (aud.write_audio_out !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %0b want 0", aud.write_audio_out); end
    n_cmp++; if (aud.left_channel_audio_out !== '0) begin n_bad++; $display("FAIL reset_left: got %h want 0", aud.left_channel_audio_out); end
    n_cmp++; if (aud.right_channel_audio_out !== '0) begin n_bad++; $display("FAIL reset_right: got %h want 0", aud.right_channel_audio_out); end
    aud.audio_in_available = 1'b0;
    reset_n = 1'b1;
    hist.delete();
  endtask

  task automatic test_first_frame;
    logic [DW-1:0] ol, orr, el, er;
    int lat, nr;
    run_frame(32'h0010_0000, 32'hFFF0_0000, 1'b1, 4, 0, ol, orr, lat, nr);
    model_frame(32'h0010_0000, 32'hFFF0_0000, 1'b1, 4, 0, el, er);
    n_cmp++; if (nr !== 1) begin n_bad++; $display("FAIL first_reads: got %0d want 1", nr); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL first_latency: got %0d want 3", lat); end
    n_cmp++; if (ol !== el) begin n_bad++; $display("FAIL first_left: got %h want %h", ol, el); end
    n_cmp++; if (orr !== er) begin n_bad++; $display("FAIL first_right: got %h want %h", orr, er); end
    n_cmp++; if (ol !== 32'h0010_0000) begin n_bad++; $display("FAIL first_dry: got %h want 00100000", ol); end
  endtask

  task automatic test_impulse;
    logic [DW-1:0] ol, orr, el, er, l, r;
    logic [DW-1:0] got[10];
    int lat, nr;
    apply_reset();
    for (int f = 0; f < 10; f++) begin
      l = (f == 0) ? 32'h4000_0000 : 32'h0;
      r = (f == 0) ? 32'hC000_0000 : 32'h0;
      run_frame(l, r, 1'b1, 4, 1, ol, orr, lat, nr);
      model_frame(l, r, 1'b1, 4, 1, el, er);
      got[f] = ol;
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL impulse_latency f%0d: got %0d want 3", f, lat); end
      n_cmp++; if (ol !== el || orr !== er) begin n_bad++; $display("FAIL impulse_frame f%0d: got %h/%h want %h/%h", f, ol, orr, el, er); end
    end
    n_cmp++; if (got[4] !== 32'h2000_0000) begin n_bad++; $display("FAIL impulse_echo4: got %h want 20000000", got[4]); end
    n_cmp++; if (got[3] !== 32'h0) begin n_bad++; $display("FAIL impulse_early: got %h want 0", got[3]); end
`ifdef ECHO_FEEDBACK_EN
    n_cmp++; if (got[8] !== 32'h1000_0000) begin n_bad++; $display("FAIL impulse_echo8: got %h want 10000000", got[8]); end
`else
    n_cmp++; if (got[8] !== 32'h0) begin n_bad++; $display("FAIL impulse_echo8: got %h want 0", got[8]); end
`endif
  endtask

  task automatic test_saturation;
    logic [DW-1:0] ol, orr, el, er;
    int lat, nr;
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      run_frame(32'h7FFF_0000, 32'h8000_0000, 1'b1, 1, 0, ol, orr, lat, nr);
      model_frame(32'h7FFF_0000, 32'h8000_0000, 1'b1, 1, 0, el, er);
      n_cmp++; if (ol !== el || orr !== er) begin n_bad++; $display("FAIL sat_frame f%0d: got %h/%h want %h/%h", f, ol, orr, el, er); end
    end
    n_cmp++; if (ol !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL sat_pos: got %h want 7fffffff", ol); end
    n_cmp++; if (orr !== 32'h8000_0000) begin n_bad++; $display("FAIL sat_neg: got %h want 80000000", orr); end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] ol, orr, el, er, l;
    logic [DW-1:0] got[DEPTH+5];
    int lat, nr;
    apply_reset();
    for (int f = 0; f < DEPTH + 5; f++) begin
      l = (f == 0) ? 32'h4000_0000 : 32'h0;
      run_frame(l, 32'h0, 1'b1, DEPTH - 1, 1, ol, orr, lat, nr);
      model_frame(l, 32'h0, 1'b1, DEPTH - 1, 1, el, er);
      got[f] = ol;
      n_cmp++; if (lat !== 3 || ol !== el || orr !== er) begin n_bad++; $display("FAIL wrap_frame f%0d: got %h/%h lat %0d want %h/%h lat 3", f, ol, orr, lat, el, er); end
    end
    n_cmp++; if (got[DEPTH-1] !== 32'h2000_0000) begin n_bad++; $display("FAIL wrap_echo: got %h want 20000000", got[DEPTH-1]); end
    n_cmp++; if (got[DEPTH-2] !== 32'h0 || got[DEPTH] !== 32'h0) begin n_bad++; $display("FAIL wrap_neighbours: got %h/%h want 0/0", got[DEPTH-2], got[DEPTH]); end
  endtask

  task automatic test_random;
    logic [DW-1:0] ol, orr, el, er, l, r;
    int lat, nr, d, sh;
    bit en;
    for (int f = 0; f < 60; f++) begin
      l  = $urandom();
      r  = $urandom();
      en = 1'($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 8));
      sh = int'($urandom_range(0, 7));
      run_frame(l, r, en, d, sh, ol, orr, lat, nr);
      model_frame(l, r, en, d, sh, el, er);
      n_cmp++; if (lat !== 3 || nr !== 1 || ol !== el || orr !== er) begin n_bad++; $display("FAIL random f%0d: got %h/%h lat %0d reads %0d want %h/%h lat 3 reads 1", f, ol, orr, lat, nr, el, er); end
    end
  endtask

  task automatic test_backpressure;
    int reads, writes;
    reads  = 0;
    writes = 0;
    @(negedge clk);
    aud.audio_in_available     = 1'b1;
    aud.audio_out_allowed      = 1'b0;
    aud.left_channel_audio_in  = $urandom();
    aud.right_channel_audio_in = $urandom();
    repeat (20) begin
      @(negedge clk);
      if (aud.read_audio_in === 1'b1) reads++;
      if (aud.write_audio_out === 1'b1) writes++;
    end
    aud.audio_in_available = 1'b0;
    aud.audio_out_allowed  = 1'b1;
    n_cmp++; if (reads !== 0) begin n_bad++; $display("FAIL bp_reads: got %0d want 0", reads); end
    n_cmp++; if (writes !== 0) begin n_bad++; $display("FAIL bp_writes: got %0d want 0", writes); end
    n_cmp++; if (aud.left_channel_audio_out !== last_el || aud.right_channel_audio_out !== last_er) begin n_bad++; $display("FAIL bp_hold: got %h/%h want %h/%h", aud.left_channel_audio_out, aud.right_channel_audio_out, last_el, last_er); end
  endtask

  task automatic test_reset_in_mix;
    logic [DW-1:0] ol, orr, el, er;
    int t, strobes, lat, nr;
    @(negedge clk);
    aud.left_channel_audio_in  = 32'h1234_5678;
    aud.right_channel_audio_in = 32'h8765_4321;
    enable                     = 1'b1;
    delay_len                  = AW'(1);
    aud.audio_in_available     = 1'b1;
    aud.audio_out_allowed      = 1'b1;
    t = 0;
    while (aud.read_audio_in !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (aud.read_audio_in !== 1'b1) begin n_bad++; $display("FAIL abort_start: read strobe timeout, got 0 want 1"); end
    aud.audio_in_available = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (aud.left_channel_audio_out !== '0 || aud.right_channel_audio_out !== '0) begin n_bad++; $display("FAIL abort_outputs: got %h/%h want 0/0", aud.left_channel_audio_out, aud.right_channel_audio_out); end
    strobes = 0;
    repeat (3) begin
      @(negedge clk);
      if (aud.write_audio_out === 1'b1 || aud.read_audio_in === 1'b1) strobes++;
    end
    reset_n = 1'b1;
    hist.delete();
    repeat (6) begin
      @(negedge clk);
      if (aud.write_audio_out === 1'b1 || aud.read_audio_in === 1'b1) strobes++;
    end
    n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL abort_strobes: got %0d want 0", strobes); end
    run_frame(32'h0100_0000, 32'hFF00_0000, 1'b1, 2, 2, ol, orr, lat, nr);
    model_frame(32'h0100_0000, 32'hFF00_0000, 1'b1, 2, 2, el, er);
    n_cmp++; if (lat !== 3 || ol !== el || orr !== er) begin n_bad++; $display("FAIL abort_recover: got %h/%h lat %0d want %h/%h lat 3", ol, orr, lat, el, er); end
  endtask

  initial begin
    reset_n                    = 1'b0;
    enable                     = 1'b0;
    delay_len                  = '0;
    decay_shift                = '0;
    aud.audio_in_available     = 1'b0;
    aud.audio_out_allowed      = 1'b0;
    aud.left_channel_audio_in  = '0;
    aud.right_channel_audio_in = '0;
    last_el                    = '0;
    last_er                    = '0;
    test_reset();
    test_first_frame();
    test_impulse();
    test_saturation();
    test_wrap();
    test_random();
    test_backpressure();
    test_reset_in_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
